// File: rtl/sop_array_if.sv
// Handshake/data bundle for sop_array: channel inputs, serial config port, outputs.
interface sop_array_if #(
  parameter int N_CH = 2,
  parameter int N_IN = 6
);
  logic [N_CH*N_IN-1:0] in_bus;
  logic                 cfg_start;
  logic                 cfg_valid;
  logic                 cfg_data;
  logic                 cfg_busy;
  logic                 cfg_done;
  logic [N_CH-1:0]      y;

  modport master (
    output in_bus, cfg_start, cfg_valid, cfg_data,
    input  cfg_busy, cfg_done, y
  );

  modport slave (
    input  in_bus, cfg_start, cfg_valid, cfg_data,
    output cfg_busy, cfg_done, y
  );
endinterface

// File: rtl/sop_array.sv
// Runtime-programmable sum-of-products array: N_CH channels, each an OR of N_TERMS
// masked AND terms with optional inversion; config shifted serially, committed atomically.
module sop_array #(
  parameter int N_CH    = 2,
  parameter int N_TERMS = 2,
  parameter int N_IN    = 6
) (
  input  logic     clk,
  input  logic     rst_n,
  sop_array_if.slave bus
);
  localparam int CH_W = N_TERMS*N_IN + 1;
  localparam int L    = N_CH*CH_W;
  localparam int CW   = $clog2(L+1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            shift_en;
  logic [L-1:0]    shadow, active;
  logic            busy, done;
  logic [N_CH-1:0] y, y_nxt;

  logic [N_CH-1:0][N_TERMS-1:0] term;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cfg_start) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        // a restart wins over a data bit presented in the same cycle
        if (bus.cfg_start) begin
          cnt_nxt = '0;
        end else if (bus.cfg_valid) begin
          shift_en = 1'b1;
          cnt_nxt  = cnt + 1'b1;
          if (cnt == CW'(L-1)) state_nxt = COMMIT;
        end
      end
      COMMIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      shadow <= '0;
      active <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      y      <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      for (int i = 0; i < L; i++)
        if (shift_en && cnt == CW'(i)) shadow[i] <= bus.cfg_data;
      if (state == COMMIT) active <= shadow;
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == COMMIT);
      y    <= y_nxt;
    end
  end

  // Evaluation always uses the committed config, so loads never disturb y.
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [N_IN-1:0] in_c;
    assign in_c = bus.in_bus[c*N_IN +: N_IN];
    for (genvar t = 0; t < N_TERMS; t++) begin : g_term
      logic [N_IN-1:0] m;
      assign m = active[c*CH_W + t*N_IN +: N_IN];
      // empty mask disables the term rather than making it a vacuous 1
      assign term[c][t] = (|m) & (&(in_c | ~m));
    end
    assign y_nxt[c] = active[c*CH_W + N_TERMS*N_IN] ^ (|term[c]);
  end

  assign bus.cfg_busy = busy;
  assign bus.cfg_done = done;
  assign bus.y        = y;
endmodule
